// File: rtl/counter_bank_if.sv
// Command, read-port and status bundle for counter_bank.
// The master drives commands and rd_ch; the slave returns read data and flags.
interface counter_bank_if #(
  parameter int unsigned DATA_SIZE = 11,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CH_W      = 2
);
  logic [CH_W-1:0]      ch;
  logic                 load;
  logic                 inc;
  logic                 dec;
  logic [DATA_SIZE-1:0] in;
  logic [DATA_SIZE-1:0] step;
  logic                 clr_flags;
  logic [CH_W-1:0]      rd_ch;
  logic [DATA_SIZE-1:0] rd_data;
  logic [CHANNELS-1:0]  ovf;
  logic [CHANNELS-1:0]  unf;
  logic [CHANNELS-1:0]  zero;

  modport master (
    output ch, load, inc, dec, in, step, clr_flags, rd_ch,
    input  rd_data, ovf, unf, zero
  );

  modport slave (
    input  ch, load, inc, dec, in, step, clr_flags, rd_ch,
    output rd_data, ovf, unf, zero
  );
endinterface

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with sticky over/underflow flags,
// a registered read port and per-channel combinational zero detect.
module counter_bank #(
  parameter int unsigned DATA_SIZE = 11,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SATURATE  = 0
) (
  input  logic          clk,
  input  logic          rst,
  counter_bank_if.slave bus
);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SUM_W = DATA_SIZE + 1;

  typedef logic [DATA_SIZE-1:0] word_t;

  word_t               cnt_q [CHANNELS];
  word_t               cnt_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] unf_q, unf_d;
  word_t               rd_data_q, rd_data_d;

  word_t               cur_c;
  logic [SUM_W-1:0]    sum_c;
  word_t               diff_c;
  logic                borrow_c;

  // Select the addressed counter and the read-port counter; unmatched selects yield 0.
  always_comb begin
    cur_c     = '0;
    rd_data_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (bus.ch == CH_W'(i))    cur_c     = cnt_q[i];
      if (bus.rd_ch == CH_W'(i)) rd_data_d = cnt_q[i];
    end
  end

  assign sum_c    = {1'b0, cur_c} + {1'b0, bus.step};
  assign diff_c   = cur_c - bus.step;
  assign borrow_c = bus.step > cur_c;

  // Next counter/flag state; a fresh flag set overrides clr_flags in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = bus.clr_flags ? '0 : ovf_q;
    unf_d = bus.clr_flags ? '0 : unf_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (bus.ch == CH_W'(i)) begin
        if (bus.load) begin
          cnt_d[i] = bus.in;
        end else if (bus.inc) begin
          if (sum_c[DATA_SIZE]) begin
            ovf_d[i] = 1'b1;
            cnt_d[i] = (SATURATE != 0) ? '1 : sum_c[DATA_SIZE-1:0];
          end else begin
            cnt_d[i] = sum_c[DATA_SIZE-1:0];
          end
        end else if (bus.dec) begin
          if (borrow_c) begin
            unf_d[i] = 1'b1;
            cnt_d[i] = (SATURATE != 0) ? '0 : diff_c;
          end else begin
            cnt_d[i] = diff_c;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= '0;
      ovf_q     <= '0;
      unf_q     <= '0;
      rd_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    bus.zero = '0;
    for (int i = 0; i < int'(CHANNELS); i++) bus.zero[i] = (cnt_q[i] == '0);
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: wrapping 4-channel, saturating 4-channel
// and 3-channel instances sharing one clock and reset.
module tb_counter_bank;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  counter_bank_if #(.DATA_SIZE(11), .CHANNELS(4), .CH_W(2)) bw ();
  counter_bank_if #(.DATA_SIZE(11), .CHANNELS(4), .CH_W(2)) bs ();
  counter_bank_if #(.DATA_SIZE(11), .CHANNELS(3), .CH_W(2)) b3 ();

  counter_bank #(.DATA_SIZE(11), .CHANNELS(4), .SATURATE(0)) u_wrap (.clk(clk), .rst(rst), .bus(bw.slave));
  counter_bank #(.DATA_SIZE(11), .CHANNELS(4), .SATURATE(1)) u_sat  (.clk(clk), .rst(rst), .bus(bs.slave));
  counter_bank #(.DATA_SIZE(11), .CHANNELS(3), .SATURATE(0)) u_c3   (.clk(clk), .rst(rst), .bus(b3.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bw.ch = '0; bw.load = 0; bw.inc = 0; bw.dec = 0; bw.in = '0; bw.step = '0; bw.clr_flags = 0; bw.rd_ch = '0;
    bs.ch = '0; bs.load = 0; bs.inc = 0; bs.dec = 0; bs.in = '0; bs.step = '0; bs.clr_flags = 0; bs.rd_ch = '0;
    b3.ch = '0; b3.load = 0; b3.inc = 0; b3.dec = 0; b3.in = '0; b3.step = '0; b3.clr_flags = 0; b3.rd_ch = '0;
  endtask

  task automatic rd_w(input int c, output logic [10:0] v);
    bw.load = 0; bw.inc = 0; bw.dec = 0; bw.rd_ch = 2'(c);
    tick();
    v = bw.rd_data;
  endtask

  task automatic rd_s(input int c, output logic [10:0] v);
    bs.load = 0; bs.inc = 0; bs.dec = 0; bs.rd_ch = 2'(c);
    tick();
    v = bs.rd_data;
  endtask

  task automatic rd_3(input int c, output logic [10:0] v);
    b3.load = 0; b3.inc = 0; b3.dec = 0; b3.rd_ch = 2'(c);
    tick();
    v = b3.rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    tick(); tick();
    checks++; if (bw.rd_data !== 11'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", bw.rd_data); end
    checks++; if (bw.zero !== 4'b1111) begin errors++; $display("FAIL reset_zero: got %b expected 1111", bw.zero); end
    checks++; if ({bw.ovf, bw.unf} !== 8'h00) begin errors++; $display("FAIL reset_flags: got %b expected 0", {bw.ovf, bw.unf}); end
    checks++; if (b3.zero !== 3'b111) begin errors++; $display("FAIL reset_zero_c3: got %b expected 111", b3.zero); end
    rst = 1'b0;
  endtask

  task automatic test_load_readback();
    logic [10:0] v;
    bw.ch = 2; bw.load = 1; bw.in = 11'd100;
    tick();
    bw.load = 0;
    checks++; if (bw.zero !== 4'b1011) begin errors++; $display("FAIL load_zero: got %b expected 1011", bw.zero); end
    rd_w(2, v);
    checks++; if (v !== 11'd100) begin errors++; $display("FAIL load_readback: got %0d expected 100", v); end
    // read and increment the same channel on one edge: read shows the old value
    bw.ch = 2; bw.inc = 1; bw.step = 11'd5; bw.rd_ch = 2;
    tick();
    checks++; if (bw.rd_data !== 11'd100) begin errors++; $display("FAIL no_write_through: got %0d expected 100", bw.rd_data); end
    rd_w(2, v);
    checks++; if (v !== 11'd105) begin errors++; $display("FAIL inc_readback: got %0d expected 105", v); end
  endtask

  task automatic test_wrap();
    logic [10:0] v;
    bw.ch = 1; bw.load = 1; bw.in = 11'd2040;
    tick();
    bw.load = 0; bw.inc = 1; bw.step = 11'd10;
    tick();
    bw.inc = 0;
    checks++; if (bw.ovf !== 4'b0010) begin errors++; $display("FAIL wrap_ovf: got %b expected 0010", bw.ovf); end
    rd_w(1, v);
    checks++; if (v !== 11'd2) begin errors++; $display("FAIL wrap_inc_value: got %0d expected 2", v); end
    bw.ch = 1; bw.dec = 1; bw.step = 11'd5;
    tick();
    bw.dec = 0;
    checks++; if (bw.unf !== 4'b0010) begin errors++; $display("FAIL wrap_unf: got %b expected 0010", bw.unf); end
    rd_w(1, v);
    checks++; if (v !== 11'd2045) begin errors++; $display("FAIL wrap_dec_value: got %0d expected 2045", v); end
    // step 0 on an empty channel: no borrow, no change
    bw.ch = 0; bw.dec = 1; bw.step = 11'd0;
    tick();
    bw.dec = 0;
    checks++; if (bw.unf !== 4'b0010) begin errors++; $display("FAIL step0_unf: got %b expected 0010", bw.unf); end
    checks++; if (bw.zero !== 4'b1001) begin errors++; $display("FAIL step0_zero: got %b expected 1001", bw.zero); end
  endtask

  task automatic test_priority();
    logic [10:0] v;
    bw.ch = 3; bw.load = 1; bw.inc = 1; bw.dec = 1; bw.in = 11'd55; bw.step = 11'd9;
    tick();
    bw.load = 0; bw.step = 11'd1;
    tick();
    bw.inc = 0; bw.dec = 0;
    rd_w(3, v);
    checks++; if (v !== 11'd56) begin errors++; $display("FAIL priority_ch3: got %0d expected 56", v); end
    rd_w(0, v);
    checks++; if (v !== 11'd0) begin errors++; $display("FAIL isolation_ch0: got %0d expected 0", v); end
    rd_w(1, v);
    checks++; if (v !== 11'd2045) begin errors++; $display("FAIL isolation_ch1: got %0d expected 2045", v); end
    rd_w(2, v);
    checks++; if (v !== 11'd105) begin errors++; $display("FAIL isolation_ch2: got %0d expected 105", v); end
  endtask

  task automatic test_flag_race();
    bw.clr_flags = 1;
    tick();
    bw.clr_flags = 0;
    checks++; if ({bw.ovf, bw.unf} !== 8'h00) begin errors++; $display("FAIL clr_flags: got %b expected 0", {bw.ovf, bw.unf}); end
    bw.ch = 0; bw.load = 1; bw.in = 11'd2047;
    tick();
    bw.load = 0; bw.inc = 1; bw.step = 11'd1; bw.clr_flags = 1;
    tick();
    bw.inc = 0; bw.clr_flags = 0;
    checks++; if (bw.ovf !== 4'b0001) begin errors++; $display("FAIL race_set_wins: got %b expected 0001", bw.ovf); end
    checks++; if (bw.zero[0] !== 1'b1) begin errors++; $display("FAIL race_wrap_zero: got %b expected 1", bw.zero[0]); end
    tick();
    checks++; if (bw.ovf !== 4'b0001) begin errors++; $display("FAIL flag_sticky: got %b expected 0001", bw.ovf); end
    bw.clr_flags = 1;
    tick();
    bw.clr_flags = 0;
    checks++; if (bw.ovf !== 4'b0000) begin errors++; $display("FAIL clr_after_race: got %b expected 0000", bw.ovf); end
  endtask

  task automatic test_illegal_channel();
    logic [10:0] v;
    b3.ch = 0; b3.load = 1; b3.in = 11'd7;
    tick();
    b3.ch = 3; b3.load = 1; b3.in = 11'd99;
    tick();
    b3.load = 0; b3.inc = 1; b3.step = 11'd2047;
    tick();
    b3.inc = 0;
    checks++; if (b3.zero !== 3'b110) begin errors++; $display("FAIL illegal_zero: got %b expected 110", b3.zero); end
    checks++; if (b3.ovf !== 3'b000) begin errors++; $display("FAIL illegal_ovf: got %b expected 000", b3.ovf); end
    rd_3(3, v);
    checks++; if (v !== 11'd0) begin errors++; $display("FAIL illegal_rd_ch: got %0d expected 0", v); end
    rd_3(0, v);
    checks++; if (v !== 11'd7) begin errors++; $display("FAIL illegal_ch0_kept: got %0d expected 7", v); end
  endtask

  task automatic test_saturate();
    logic [10:0] v;
    bs.ch = 0; bs.load = 1; bs.in = 11'd2040;
    tick();
    bs.load = 0; bs.inc = 1; bs.step = 11'd10;
    tick();
    bs.inc = 0;
    checks++; if (bs.ovf !== 4'b0001) begin errors++; $display("FAIL sat_ovf: got %b expected 0001", bs.ovf); end
    rd_s(0, v);
    checks++; if (v !== 11'd2047) begin errors++; $display("FAIL sat_high: got %0d expected 2047", v); end
    bs.ch = 0; bs.load = 1; bs.in = 11'd3;
    tick();
    bs.load = 0; bs.dec = 1; bs.step = 11'd7;
    tick();
    bs.dec = 0;
    checks++; if (bs.unf !== 4'b0001) begin errors++; $display("FAIL sat_unf: got %b expected 0001", bs.unf); end
    checks++; if (bs.zero[0] !== 1'b1) begin errors++; $display("FAIL sat_zero: got %b expected 1", bs.zero[0]); end
    rd_s(0, v);
    checks++; if (v !== 11'd0) begin errors++; $display("FAIL sat_low: got %0d expected 0", v); end
  endtask

  task automatic test_async_reset();
    bw.ch = 1; bw.inc = 1; bw.step = 11'd1; bw.rd_ch = 1;
    tick(); tick(); tick();
    checks++; if (bw.rd_data !== 11'd2047) begin errors++; $display("FAIL stream_rd_data: got %0d expected 2047", bw.rd_data); end
    checks++; if (bw.ovf !== 4'b0010) begin errors++; $display("FAIL stream_ovf: got %b expected 0010", bw.ovf); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bw.rd_data !== 11'd0) begin errors++; $display("FAIL async_rd_data: got %0d expected 0", bw.rd_data); end
    checks++; if ({bw.ovf, bw.unf} !== 8'h00) begin errors++; $display("FAIL async_flags: got %b expected 0", {bw.ovf, bw.unf}); end
    checks++; if (bw.zero !== 4'b1111) begin errors++; $display("FAIL async_zero: got %b expected 1111", bw.zero); end
    tick();
    checks++; if (bw.zero !== 4'b1111) begin errors++; $display("FAIL cmd_in_reset: got %b expected 1111", bw.zero); end
    rst = 1'b0;
    tick();
    checks++; if (bw.zero !== 4'b1101) begin errors++; $display("FAIL resume_zero: got %b expected 1101", bw.zero); end
    bw.inc = 0;
    tick();
    checks++; if (bw.rd_data !== 11'd1) begin errors++; $display("FAIL resume_value: got %0d expected 1", bw.rd_data); end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_load_readback();
    test_wrap();
    test_priority();
    test_flag_race();
    test_illegal_channel();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter DATA_SIZE, default 11: counter width in bits; legal range 2 to 32.
REQ-002 Parameter CHANNELS, default 4: number of independent counters; legal range 1 to 16.
REQ-003 Parameter SATURATE, default 0: 0 = wrap on over/underflow, 1 = clamp at limits.
REQ-004 Derived constant CH_W SHALL be max(1, clog2(CHANNELS)).
REQ-005 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 ch  in  CH_W  channel addressed by load/inc/dec.
REQ-008 load  in  1  write `in` to channel ch.
REQ-009 inc  in  1  add `step` to channel ch.
REQ-010 dec  in  1  subtract `step` from channel ch.
REQ-011 in  in  DATA_SIZE  load value.
REQ-012 step  in  DATA_SIZE  increment/decrement amount, unsigned.
REQ-013 clr_flags  in  1  clear all sticky flags.
REQ-014 rd_ch  in  CH_W  read-port channel select.
REQ-015 rd_data  out  DATA_SIZE  registered value of channel rd_ch.
REQ-016 ovf  out  CHANNELS  sticky overflow flag, one bit per channel.
REQ-017 unf  out  CHANNELS  sticky underflow flag, one bit per channel.
REQ-018 zero  out  CHANNELS  per-channel value == 0, combinational from counter state.

Function
REQ-019 Per cycle, only channel ch SHALL change value; all other channels SHALL hold.
REQ-020 Command priority SHALL be load > inc > dec; with inc=dec=1 and load=0, inc SHALL apply.
REQ-021 load SHALL set value to `in` and SHALL NOT set ovf/unf.
REQ-022 inc: the sum value+step SHALL be formed at DATA_SIZE+1 bits; if the sum exceeds 2^DATA_SIZE-1, ovf[ch] SHALL set.
REQ-023 inc overflow result: SATURATE=0 -> sum mod 2^DATA_SIZE; SATURATE=1 -> 2^DATA_SIZE-1.
REQ-024 dec: if step > value, unf[ch] SHALL set; result SATURATE=0 -> (value-step) mod 2^DATA_SIZE; SATURATE=1 -> 0.
REQ-025 step=0 with inc or dec SHALL leave the value unchanged and set no flag.
REQ-026 If ch >= CHANNELS, load/inc/dec SHALL be ignored entirely.
REQ-027 If rd_ch >= CHANNELS, rd_data SHALL load 0.
REQ-028 rd_data SHALL have 1-cycle latency and SHALL show the counter state before that edge's update, with no write-through.
REQ-029 clr_flags SHALL zero all ovf/unf bits at the next edge.
REQ-030 If clr_flags coincides with a flag-setting event, the new flag SHALL read 1 after the edge (set wins).
REQ-031 Flags SHALL remain set until clr_flags or rst.
REQ-032 zero[i] SHALL reflect the current counter value of channel i, with no added latency.

Reset
REQ-033 rst SHALL immediately, independent of clk, force all counters, rd_data, ovf and unf to 0.
REQ-034 As a consequence of REQ-033, zero SHALL read all ones during and after reset.
REQ-035 While rst=1, all commands SHALL be ignored.
REQ-036 The first command after rst falls SHALL act at the first rising edge at which rst=0.

Verification (DATA_SIZE=11, CHANNELS=4 unless stated)
REQ-037 Reset/load/readback: rst pulse -> rd_data=0, zero=4'b1111; load ch=2, in=100; next cycle rd_ch=2 -> rd_data=100 one cycle later, zero=4'b1011.
REQ-038 Wrap (SATURATE=0): load ch=1 in=2040; inc step=10 -> value 2, ovf=4'b0010; dec step=5 -> value 2045, unf=4'b0010.
REQ-039 Saturate (SATURATE=1): load ch=0 in=2040; inc step=10 -> 2047 with ovf[0]=1; load 3; dec step=7 -> 0 with unf[0]=1 and zero[0]=1.
REQ-040 Priority/isolation: ch=3, load=inc=dec=1, in=55 -> ch3=55; then inc=dec=1, step=1 -> 56; channels 0-2 unchanged throughout.
REQ-041 Flag race and illegal channel: clr_flags in the same cycle as an overflow on ch0 -> ovf[0]=1; clr_flags alone -> ovf=0. With CHANNELS=3, ch=3 load -> no state change, and rd_ch=3 -> rd_data=0.
REQ-042 Async reset mid-operation: assert rst between edges while inc streams on ch1 -> all outputs 0 before the next edge; the counter resumes from 0 after release.
